inst_buffer: RTL and testbench



---
 rtl/inst_buffer.sv | 183 ++++++++++++++++++
 tb/tb_inst_buffer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_buffer.sv
// -----------------------------------------------------------------------------
// inst_buffer
//   Decoupling FIFO between decode and the InstBuf->Rename pipeline register.
//   Up to FETCH_WIDTH decoded packets are accepted per cycle. Invalid slots
//   (bit 0 clear) are squeezed out, so valid packets land back to back. The
//   rename side only ever sees a complete DISPATCH_WIDTH bundle. Decode is
//   back-pressured whenever a worst-case bundle might not fit.
//
// Ports
//   clk               : clock
//   reset             : synchronous, active-high reset
//   flush_i           : synchronous clear (exception / mispredict)
//   stall_i           : downstream stall; holds the head bundle
//   decodeReady_i     : a decode bundle is present this cycle
//   decPacket_i[]     : FETCH_WIDTH decoded packets, bit 0 = valid
//   renPacket_o[]     : DISPATCH_WIDTH head packets (all zero when not ready)
//   instBufferReady_o : renPacket_o holds a full, valid bundle
//   instBufferFull_o  : fewer than FETCH_WIDTH free entries remain
//   occupancy_o       : number of entries held
// -----------------------------------------------------------------------------
module inst_buffer #(
    parameter int DEPTH          = 32,
    parameter int FETCH_WIDTH    = 4,
    parameter int DISPATCH_WIDTH = 4,
    parameter int PKT_WIDTH      = 64   // REN_PKT_SIZE of the enclosing core
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush_i,
    input  logic                    stall_i,
    input  logic                    decodeReady_i,
    input  logic [PKT_WIDTH-1:0]    decPacket_i [0:FETCH_WIDTH-1],
    output logic [PKT_WIDTH-1:0]    renPacket_o [0:DISPATCH_WIDTH-1],
    output logic                    instBufferReady_o,
    output logic                    instBufferFull_o,
    output logic [$clog2(DEPTH):0]  occupancy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Full when more than DEPTH-FETCH_WIDTH entries are held.
    localparam logic [CW-1:0] FULL_LIMIT = CW'(DEPTH - FETCH_WIDTH);
    localparam logic [CW-1:0] DW_COUNT   = CW'(DISPATCH_WIDTH);
    localparam logic [AW-1:0] DW_STEP    = AW'(DISPATCH_WIDTH);

    logic [PKT_WIDTH-1:0] storage [0:DEPTH-1];
    logic [AW-1:0]        head;
    logic [AW-1:0]        tail;
    logic [CW-1:0]        count;

    logic [CW-1:0]        n_push;
    logic [AW-1:0]        wr_idx   [0:FETCH_WIDTH-1];
    logic [AW-1:0]        rd_idx   [0:DISPATCH_WIDTH-1];
    logic                 full;
    logic                 ready;
    logic                 push_en;
    logic                 pop_en;
    logic [CW-1:0]        push_amt;
    logic [CW-1:0]        pop_amt;

    // Count valid slots and give each one its compacted write position.
    // A slot's offset from tail is the number of valid slots before it.
    always_comb begin
        n_push = {CW{1'b0}};
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            wr_idx[i] = tail + n_push[AW-1:0];
            if (decPacket_i[i][0]) begin
                n_push = n_push + CW'(1);
            end else begin
                n_push = n_push;
            end
        end
    end

    // Status flags and push/pop qualification.
    always_comb begin
        full    = (count > FULL_LIMIT);
        ready   = (count >= DW_COUNT) && !flush_i;
        push_en = decodeReady_i && !full && !flush_i && !reset;
        pop_en  = ready && !stall_i && !reset;
        if (push_en) begin
            push_amt = n_push;
        end else begin
            push_amt = {CW{1'b0}};
        end
        if (pop_en) begin
            pop_amt = DW_COUNT;
        end else begin
            pop_amt = {CW{1'b0}};
        end
    end

    // Head bundle: read indices wrap naturally in AW bits, so a bundle that
    // straddles DEPTH-1 -> 0 comes out in order. Zeroed when not ready so
    // every valid bit downstream is clear.
    always_comb begin
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            rd_idx[k] = head + AW'(k);
            if (ready) begin
                renPacket_o[k] = storage[rd_idx[k]];
            end else begin
                renPacket_o[k] = {PKT_WIDTH{1'b0}};
            end
        end
    end

    // Storage write: only valid slots are written, at compacted positions.
    // Contents need no reset; count gates every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (push_en && decPacket_i[i][0]) begin
                storage[wr_idx[i]] <= decPacket_i[i];
            end
        end
    end

    // Pointer and occupancy update; flush behaves like reset for the state.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            head  <= {AW{1'b0}};
            tail  <= {AW{1'b0}};
            count <= {CW{1'b0}};
        end else begin
            if (push_en) begin
                tail <= tail + n_push[AW-1:0];
            end else begin
                tail <= tail;
            end
            if (pop_en) begin
                head <= head + DW_STEP;
            end else begin
                head <= head;
            end
            count <= count + push_amt - pop_amt;
        end
    end

    assign instBufferReady_o = ready;
    assign instBufferFull_o  = full;
    assign occupancy_o       = count;

    inst_buffer_chk #(
        .DEPTH          (DEPTH),
        .DISPATCH_WIDTH (DISPATCH_WIDTH)
    ) u_chk (
        .clk    (clk),
        .reset  (reset),
        .count  (count),
        .pop_en (pop_en)
    );

endmodule

// -----------------------------------------------------------------------------
// inst_buffer_chk
//   Invariant checks for inst_buffer: occupancy never exceeds DEPTH and a pop
//   never happens without a full bundle held.
//
// Ports
//   clk, reset : as in inst_buffer
//   count      : current occupancy register
//   pop_en     : pop qualifier of this cycle
// -----------------------------------------------------------------------------
module inst_buffer_chk #(
    parameter int DEPTH          = 32,
    parameter int DISPATCH_WIDTH = 4
) (
    input logic                   clk,
    input logic                   reset,
    input logic [$clog2(DEPTH):0] count,
    input logic                   pop_en
);

    localparam int CW = $clog2(DEPTH) + 1;

    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        count <= CW'(DEPTH));

    a_pop_needs_bundle : assert property (@(posedge clk) disable iff (reset)
        pop_en |-> (count >= CW'(DISPATCH_WIDTH)));

endmodule

// File: tb/tb_inst_buffer.sv
// -----------------------------------------------------------------------------
// tb_inst_buffer
//   Self-checking bench for inst_buffer (DEPTH=16, FW=DW=4). Every cycle the
//   outputs are compared with a queue-based model of the FIFO; directed rows
//   additionally carry hand-derived occupancy/ready/full values.
// -----------------------------------------------------------------------------
module tb_inst_buffer;

    localparam int DEPTH = 16;
    localparam int FW    = 4;
    localparam int DW    = 4;
    localparam int PW    = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush_i;
    logic          stall_i;
    logic          decodeReady_i;
    logic [PW-1:0] dec [0:FW-1];
    logic [PW-1:0] ren [0:DW-1];
    logic          ready;
    logic          full;
    logic [4:0]    occ;

    inst_buffer #(
        .DEPTH          (DEPTH),
        .FETCH_WIDTH    (FW),
        .DISPATCH_WIDTH (DW),
        .PKT_WIDTH      (PW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .flush_i           (flush_i),
        .stall_i           (stall_i),
        .decodeReady_i     (decodeReady_i),
        .decPacket_i       (dec),
        .renPacket_o       (ren),
        .instBufferReady_o (ready),
        .instBufferFull_o  (full),
        .occupancy_o       (occ)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       fl;
        bit       st;
        bit       dr;
        bit [3:0] mask;
        int       occ;
        bit       rdy;
        bit       full;
    } vec_t;

    vec_t          tab [$];
    logic [PW-1:0] model_q [$];
    int            checks   = 0;
    int            failures = 0;
    int unsigned   seq      = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input bit rst, input bit fl, input bit st, input bit dr,
                       input bit [3:0] mask, input int o, input bit r, input bit f);
        vec_t v;
        v.rst = rst; v.fl = fl; v.st = st; v.dr = dr; v.mask = mask;
        v.occ = o;   v.rdy = r; v.full = f;
        tab.push_back(v);
    endtask

    // One cycle: drive at negedge, compare mid-cycle, advance model at posedge.
    task automatic step(input bit rst, input bit fl, input bit st, input bit dr,
                        input bit [3:0] mask, input bit chk_model,
                        input bit chk_tab, input int t_occ, input bit t_rdy,
                        input bit t_full, input string tag);
        bit            m_full;
        bit            m_rdy;
        bit            pop;
        bit            push;
        logic [PW-1:0] exp_pkt;
        logic [PW-1:0] pkts [0:FW-1];
        reset = rst; flush_i = fl; stall_i = st; decodeReady_i = dr;
        for (int i = 0; i < FW; i++) begin
            pkts[i] = {seq[14:0], mask[i]};
            dec[i]  = pkts[i];
            seq++;
        end
        m_full = (DEPTH - model_q.size()) < FW;
        m_rdy  = (model_q.size() >= DW) && !fl;
        #1;
        if (chk_model) begin
            check({tag, ".occ"},   32'(occ),   32'(model_q.size()));
            check({tag, ".ready"}, 32'(ready), 32'(m_rdy));
            check({tag, ".full"},  32'(full),  32'(m_full));
            for (int k = 0; k < DW; k++) begin
                exp_pkt = m_rdy ? model_q[k] : '0;
                check($sformatf("%s.ren%0d", tag, k), 32'(ren[k]), 32'(exp_pkt));
            end
        end
        if (chk_tab) begin
            check({tag, ".tab_occ"},   32'(occ),   32'(t_occ));
            check({tag, ".tab_ready"}, 32'(ready), 32'(t_rdy));
            check({tag, ".tab_full"},  32'(full),  32'(t_full));
        end
        @(posedge clk);
        pop  = m_rdy && !st;
        push = dr && !m_full && !fl;
        if (rst || fl) begin
            model_q.delete();
        end else begin
            if (pop) begin
                for (int k = 0; k < DW; k++) void'(model_q.pop_front());
            end
            if (push) begin
                for (int i = 0; i < FW; i++) begin
                    if (mask[i]) model_q.push_back(pkts[i]);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; flush_i = 1'b0; stall_i = 1'b0; decodeReady_i = 1'b0;
        for (int i = 0; i < FW; i++) dec[i] = '0;
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0, "init");

        //   rst   fl    st    dr    mask     occ rdy   full
        // reset state
        add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 0,  1'b0, 1'b0);
        // fill with stall, fifth bundle refused, then drain
        add(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 0,  1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 4,  1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 8,  1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 12, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 16, 1'b1, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 16, 1'b1, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 12, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8,  1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4,  1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 0,  1'b0, 1'b0);
        // compaction: 1010 then 0111 -> five entries, one bundle
        add(1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, 0,  1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 4'b0111, 2,  1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 5,  1'b1, 1'b0);
        // partial hold: three entries never issue, a fourth completes a bundle
        add(1'b0, 1'b0, 1'b0, 1'b1, 4'b0011, 1,  1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3,  1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3,  1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3,  1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 3,  1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4,  1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4,  1'b1, 1'b0);
        // steady push 4 / pop 4 at count 8, crossing 15->0 twice
        add(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 0,  1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 4,  1'b1, 1'b0);
        for (int c = 0; c < 8; c++) add(1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 8, 1'b1, 1'b0);
        // flush with full buffer and a decode bundle in the same cycle
        add(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 8,  1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 12, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 16, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 0,  1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 0,  1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4,  1'b1, 1'b0);

        for (int i = 0; i < tab.size(); i++) begin
            step(tab[i].rst, tab[i].fl, tab[i].st, tab[i].dr, tab[i].mask, 1'b1,
                 1'b1, tab[i].occ, tab[i].rdy, tab[i].full, $sformatf("vec%0d", i));
        end

        // Reset mid-drain at count 12 with stall low, then push from empty.
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 0,  1'b0, 1'b0, "rst_fill0");
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 4,  1'b1, 1'b0, "rst_fill1");
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 8,  1'b1, 1'b0, "rst_fill2");
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 12, 1'b1, 1'b0, "rst_hit");
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b1, 1'b1, 0,  1'b0, 1'b0, "rst_after");
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0101, 1'b1, 1'b1, 2,  1'b0, 1'b0, "rst_push2");
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 4,  1'b1, 1'b0, "rst_issue");
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 0,  1'b0, 1'b0, "rst_empty");

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            bit       r_rst;
            bit       r_fl;
            bit       r_st;
            bit       r_dr;
            bit [3:0] r_mask;
            r_rst  = ($urandom_range(0, 149) == 0);
            r_fl   = ($urandom_range(0, 39) == 0);
            r_st   = ($urandom_range(0, 2) == 0);
            r_dr   = ($urandom_range(0, 3) != 0);
            r_mask = 4'($urandom);
            step(r_rst, r_fl, r_st, r_dr, r_mask, 1'b1, 1'b0, 0, 1'b0, 1'b0,
                 $sformatf("rnd%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
